rx_frame_checker: RTL
=====================

RX_FRAME_CHECKER -- requirements
Module: rx_frame_checker

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64: minimum legal frame length in bytes (DA through FCS).
REQ-002 SHALL have parameter MAX_LEN, default 1522: maximum legal frame length in bytes.
REQ-003 Port PHY0_REF_CLK  in  1: sole clock; all logic rises on it.
REQ-004 Port arst_n  in  1: asynchronous, active-low reset.
REQ-005 Ports in_data/in_wren/in_eod  in  8/1/1: byte stream from RMII_RX (preamble/SFD already stripped), write strobe, one-cycle end-of-data strobe.
REQ-006 Ports out_data/out_wren/out_eod  out  8/1/1: identical stream toward FRAME_FIFO.
REQ-007 Ports fifo_afull_in  in  1 and fifo_afull_out  out  1: almost-full flag from FRAME_FIFO, passed combinationally to RMII_RX.
REQ-008 Ports st_valid/st_crc_ok/st_runt/st_giant/st_len  out  1/1/1/1/11: per-frame status.
REQ-009 Ports cnt_good/cnt_crc_err/cnt_len_err  out  16/16/16: statistics counters.

Function
REQ-010 out_* SHALL equal in_* delayed exactly one cycle, unmodified; fifo_afull_out = fifo_afull_in with zero latency.
REQ-011 FSM states: IDLE, RECV, REPORT. IDLE->RECV on in_wren without in_eod. RECV->REPORT on in_eod. REPORT->IDLE after one cycle, or ->RECV if in_wren that cycle.
REQ-012 CRC32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, LSB first, updated once per in_wren byte, FCS bytes included.
REQ-013 st_crc_ok SHALL be 1 iff CRC register equals residue 0xDEBB20E3 after the last byte.
REQ-014 Length counter: 11 bits, +1 per in_wren byte, saturates at 2047.
REQ-015 in_wren and in_eod in the same cycle: that byte belongs to the ending frame.
REQ-016 In REPORT: st_valid=1 for exactly one cycle, two cycles after the in_eod cycle (one after out_eod); st_len/st_crc_ok/st_runt/st_giant held until the next st_valid.
REQ-017 st_runt = (st_len < MIN_LEN); st_giant = (st_len > MAX_LEN).
REQ-018 in_eod in IDLE with no byte seen: report st_len=0, st_crc_ok=0, st_runt=1.
REQ-019 in_wren in the REPORT cycle: CRC and length restart at that byte; no byte is lost.
REQ-020 Counters update on the st_valid cycle; saturate at 0xFFFF; never wrap.
REQ-021 Classification priority: length error (runt or giant) -> cnt_len_err; else CRC fail -> cnt_crc_err; else cnt_good. Exactly one counter increments per frame.

Reset
REQ-022 arst_n low SHALL force FSM to IDLE, CRC to 0xFFFFFFFF, length to 0, and all outputs except fifo_afull_out to 0, including mid-frame.
REQ-023 A frame cut by reset SHALL produce no st_valid and no counter change; checking restarts at the first in_wren after release.

Configuration
REQ-024 Macro RX_FRAME_STATS_EN defined: counters per REQ-020/021 are implemented.
REQ-025 Macro RX_FRAME_STATS_EN undefined: counter registers are not built, cnt_* tie to 0, ports remain, all other behaviour is unchanged.

Structure
REQ-026 Shared package eth_pkg SHALL hold CRC32_POLY, CRC32_INIT, CRC32_RESIDUE, ETH_MIN_LEN and ETH_MAX_LEN.
REQ-027 Sub-module crc32_d8 SHALL implement the combinational one-byte next-CRC function; the checker instantiates it once.

Verification
REQ-028 Bytes "123456789" followed by 26 39 F4 CB, in_eod on the last byte -> st_len=13, st_crc_ok=1, st_runt=1, cnt_len_err=1.
REQ-029 64-byte frame with FCS from a bench model -> st_crc_ok=1, st_runt=0, st_giant=0, cnt_good +1; out_* matches in_* delayed one cycle byte-for-byte.
REQ-030 Same frame with byte 10 bit-flipped -> st_crc_ok=0, cnt_crc_err +1; 1600-byte frame -> st_giant=1, cnt_len_err +1.
REQ-031 Back-to-back frames, second frame's first in_wren in the REPORT cycle -> two st_valid pulses, both st_len values correct.
REQ-032 arst_n low for 2 cycles at byte 30 of a frame, then a good 64-byte frame -> only one st_valid, with st_len=64 and st_crc_ok=1.
REQ-033 in_eod alone in IDLE -> st_len=0, st_runt=1, st_crc_ok=0; 65536 runts -> cnt_len_err holds at 0xFFFF.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet constants, FSM state type and small helper functions
// used by the RX frame checker and its CRC sub-module.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
    localparam int          ETH_MIN_LEN   = 64;
    localparam int          ETH_MAX_LEN   = 1522;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_REPORT = 2'd2
    } rx_state_t;

    // One byte of reflected CRC-32, data consumed LSB first, no final inversion.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if ((c[0] ^ data[i]) == 1'b1) begin
                c = (c >> 1) ^ CRC32_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Saturating 16-bit increment: sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte next-state function of the Ethernet CRC-32.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // Advance the CRC by one data byte.
    always_comb begin
        crc_out = crc32_byte(crc_in, data);
    end

endmodule

// File: rtl/rx_frame_checker.sv
// In-line RX frame checker between RMII_RX and FRAME_FIFO.
// Passes the byte stream through with one cycle of delay, checks each
// frame's FCS and length, and reports per-frame status one cycle after
// the delayed end-of-data strobe.
// Optional build macro: RX_FRAME_STATS_EN enables the statistics
// counters; without it cnt_* are tied to zero.
module rx_frame_checker
    import eth_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int MAX_LEN = ETH_MAX_LEN
) (
    input  logic        PHY0_REF_CLK,
    input  logic        arst_n,
    input  logic [7:0]  in_data,
    input  logic        in_wren,
    input  logic        in_eod,
    output logic [7:0]  out_data,
    output logic        out_wren,
    output logic        out_eod,
    input  logic        fifo_afull_in,
    output logic        fifo_afull_out,
    output logic        st_valid,
    output logic        st_crc_ok,
    output logic        st_runt,
    output logic        st_giant,
    output logic [10:0] st_len,
    output logic [15:0] cnt_good,
    output logic [15:0] cnt_crc_err,
    output logic [15:0] cnt_len_err
);

    localparam logic [10:0] MIN_LEN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);
    localparam logic [10:0] LEN_SAT   = 11'h7FF;

    rx_state_t   state_r;
    logic [31:0] crc_r;
    logic [10:0] len_r;
    logic [31:0] base_crc_s;
    logic [10:0] base_len_s;
    logic [31:0] upd_crc_s;
    logic [31:0] cur_crc_s;
    logic [10:0] cur_len_s;

    // Result of the most recently ended frame, waiting for the REPORT cycle.
    logic [10:0] rep_len_r;
    logic        rep_crc_ok_r;
    logic        rep_runt_s;
    logic        rep_giant_s;

    logic [7:0]  out_data_r;
    logic        out_wren_r;
    logic        out_eod_r;
    logic        st_valid_r;
    logic        st_crc_ok_r;
    logic        st_runt_r;
    logic        st_giant_r;
    logic [10:0] st_len_r;

    crc32_d8 u_crc32_d8 (
        .crc_in  (base_crc_s),
        .data    (in_data),
        .crc_out (upd_crc_s)
    );

    // Running CRC/length including this cycle's byte; a new frame starts from INIT outside RECV.
    always_comb begin
        base_crc_s = CRC32_INIT;
        base_len_s = 11'd0;
        cur_crc_s  = CRC32_INIT;
        cur_len_s  = 11'd0;
        if (state_r == ST_RECV) begin
            base_crc_s = crc_r;
            base_len_s = len_r;
        end else begin
            base_crc_s = CRC32_INIT;
            base_len_s = 11'd0;
        end
        if (in_wren) begin
            cur_crc_s = upd_crc_s;
            if (base_len_s == LEN_SAT) begin
                cur_len_s = base_len_s;
            end else begin
                cur_len_s = base_len_s + 11'd1;
            end
        end else begin
            cur_crc_s = base_crc_s;
            cur_len_s = base_len_s;
        end
    end

    // Length classification of the pending report.
    always_comb begin
        rep_runt_s  = (rep_len_r < MIN_LEN_L);
        rep_giant_s = (rep_len_r > MAX_LEN_L);
    end

    // One-cycle pass-through of the byte stream toward the FIFO.
    always_ff @(posedge PHY0_REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            out_data_r <= 8'h00;
            out_wren_r <= 1'b0;
            out_eod_r  <= 1'b0;
        end else begin
            out_data_r <= in_data;
            out_wren_r <= in_wren;
            out_eod_r  <= in_eod;
        end
    end

    // Frame FSM with CRC/length accumulation and registered status outputs.
    always_ff @(posedge PHY0_REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            state_r      <= ST_IDLE;
            crc_r        <= CRC32_INIT;
            len_r        <= 11'd0;
            rep_len_r    <= 11'd0;
            rep_crc_ok_r <= 1'b0;
            st_valid_r   <= 1'b0;
            st_crc_ok_r  <= 1'b0;
            st_runt_r    <= 1'b0;
            st_giant_r   <= 1'b0;
            st_len_r     <= 11'd0;
        end else begin
            if (in_eod) begin
                rep_len_r    <= cur_len_s;
                rep_crc_ok_r <= (cur_crc_s == CRC32_RESIDUE);
                crc_r        <= CRC32_INIT;
                len_r        <= 11'd0;
            end else begin
                crc_r        <= cur_crc_s;
                len_r        <= cur_len_s;
            end

            if (state_r == ST_REPORT) begin
                st_valid_r  <= 1'b1;
                st_len_r    <= rep_len_r;
                st_crc_ok_r <= rep_crc_ok_r;
                st_runt_r   <= rep_runt_s;
                st_giant_r  <= rep_giant_s;
            end else begin
                st_valid_r  <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (in_eod) begin
                        state_r <= ST_REPORT;
                    end else if (in_wren) begin
                        state_r <= ST_RECV;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    if (in_eod) begin
                        state_r <= ST_REPORT;
                    end else begin
                        state_r <= ST_RECV;
                    end
                end
                ST_REPORT: begin
                    if (in_eod) begin
                        state_r <= ST_REPORT;
                    end else if (in_wren) begin
                        state_r <= ST_RECV;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RX_FRAME_STATS_EN
    logic [15:0] cnt_good_r;
    logic [15:0] cnt_crc_err_r;
    logic [15:0] cnt_len_err_r;

    // Exactly one saturating counter per reported frame; length errors win over CRC errors.
    always_ff @(posedge PHY0_REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            cnt_good_r    <= 16'h0000;
            cnt_crc_err_r <= 16'h0000;
            cnt_len_err_r <= 16'h0000;
        end else begin
            if (state_r == ST_REPORT) begin
                if (rep_runt_s || rep_giant_s) begin
                    cnt_len_err_r <= sat_inc16(cnt_len_err_r);
                end else if (!rep_crc_ok_r) begin
                    cnt_crc_err_r <= sat_inc16(cnt_crc_err_r);
                end else begin
                    cnt_good_r    <= sat_inc16(cnt_good_r);
                end
            end else begin
                cnt_good_r    <= cnt_good_r;
            end
        end
    end

    assign cnt_good    = cnt_good_r;
    assign cnt_crc_err = cnt_crc_err_r;
    assign cnt_len_err = cnt_len_err_r;
`else
    assign cnt_good    = 16'h0000;
    assign cnt_crc_err = 16'h0000;
    assign cnt_len_err = 16'h0000;
`endif

    assign fifo_afull_out = fifo_afull_in;
    assign out_data       = out_data_r;
    assign out_wren       = out_wren_r;
    assign out_eod        = out_eod_r;
    assign st_valid       = st_valid_r;
    assign st_crc_ok      = st_crc_ok_r;
    assign st_runt        = st_runt_r;
    assign st_giant       = st_giant_r;
    assign st_len         = st_len_r;

endmodule
